// File: rtl/smi_rx_stream_sched_if.sv
// Bus bundle for the SMI RX stream scheduler: ioc register port, both FIFO read
// ports, the serializer word port and FSM debug taps. slave = scheduler side.
interface smi_rx_stream_sched_if;
  logic [4:0]  i_ioc;
  logic [7:0]  i_data_in;
  logic        i_cs;
  logic        i_fetch_cmd;
  logic        i_load_cmd;
  logic [7:0]  o_data_out;
  logic        i_ch0_fifo_empty;
  logic [31:0] i_ch0_fifo_data;
  logic        o_ch0_fifo_pull;
  logic        i_ch1_fifo_empty;
  logic [31:0] i_ch1_fifo_data;
  logic        o_ch1_fifo_pull;
  logic        i_word_req;
  logic [31:0] o_word_data;
  logic        o_word_valid;
  logic        o_word_channel;
  logic        o_smi_dreq;
  logic [1:0]  dbg_state;
  logic        dbg_rr_ptr;

  modport slave (
    input  i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
    input  i_ch0_fifo_empty, i_ch0_fifo_data, i_ch1_fifo_empty, i_ch1_fifo_data,
    input  i_word_req,
    output o_data_out, o_ch0_fifo_pull, o_ch1_fifo_pull,
    output o_word_data, o_word_valid, o_word_channel, o_smi_dreq,
    output dbg_state, dbg_rr_ptr
  );

  modport master (
    output i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
    output i_ch0_fifo_empty, i_ch0_fifo_data, i_ch1_fifo_empty, i_ch1_fifo_data,
    output i_word_req,
    input  o_data_out, o_ch0_fifo_pull, o_ch1_fifo_pull,
    input  o_word_data, o_word_valid, o_word_channel, o_smi_dreq,
    input  dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/smi_rx_stream_sched.sv
// Arbitrates the single SMI read path between two RX sample FIFOs, one 32-bit
// word at a time, in bursts of up to BURST_WORDS words per grant.
module smi_rx_stream_sched #(
  parameter int         BURST_WORDS    = 16,
  parameter logic [7:0] MODULE_VERSION = 8'h02
) (
  input logic                  i_sys_clk,
  input logic                  i_reset,
  smi_rx_stream_sched_if.slave bus
);
  // Word handshake: o_word_valid high means o_word_data/o_word_channel hold an
  // unconsumed word and stay stable; one i_word_req pulse consumes it, and an
  // i_word_req seen while nothing is offered is a stray request (underrun).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULL    = 2'd1,
    LATCH   = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(BURST_WORDS - 1);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        rr_ptr_q;
  logic [7:0]  burst_cnt_q;
  logic [7:0]  word_cnt_q;
  logic        underrun_q;
  logic [2:0]  ctrl_q;
  logic [31:0] word_data_q;
  logic        word_valid_q;
  logic        word_channel_q;
  logic [7:0]  data_out_q;
  logic [7:0]  rd_mux;

  logic reg_wr, reg_rd, flush;
  logic elig0, elig1, any_elig, grant_pick;
  logic grant_empty, grant_en, consume, burst_done, stray_req;
  logic ch0_pull, ch1_pull;

  always_comb begin
    reg_wr      = bus.i_cs && bus.i_load_cmd && (bus.i_ioc == 5'd1);
    reg_rd      = bus.i_cs && bus.i_fetch_cmd;
    flush       = reg_wr && bus.i_data_in[3];
    elig0       = ctrl_q[0] && !bus.i_ch0_fifo_empty;
    elig1       = ctrl_q[1] && !bus.i_ch1_fifo_empty;
    any_elig    = elig0 || elig1;
    grant_pick  = 1'b0;
    if (ctrl_q[2])
      grant_pick = !elig0;
    else if (rr_ptr_q ? elig1 : elig0)
      grant_pick = rr_ptr_q;
    else
      grant_pick = !rr_ptr_q;
    grant_empty = grant_q ? bus.i_ch1_fifo_empty : bus.i_ch0_fifo_empty;
    grant_en    = grant_q ? ctrl_q[1] : ctrl_q[0];
    // Flush wins over a same-cycle request: it neither consumes nor underruns.
    consume     = (state_q == PRESENT) && bus.i_word_req && !flush;
    stray_req   = (state_q != PRESENT) && bus.i_word_req && !flush;
    burst_done  = (burst_cnt_q == BURST_LAST) || grant_empty || !grant_en;
  end

  // FSM state register
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          grant_d = grant_pick;
          state_d = PULL;
        end
      end
      PULL:    state_d = grant_empty ? IDLE : LATCH;
      LATCH:   state_d = PRESENT;
      PRESENT: begin
        if (consume) state_d = burst_done ? IDLE : PULL;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // FSM outputs: the pop strobe is guarded so an empty FIFO is never popped
  always_comb begin
    ch0_pull = 1'b0;
    ch1_pull = 1'b0;
    if ((state_q == PULL) && !grant_empty) begin
      ch0_pull = !grant_q;
      ch1_pull = grant_q;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      ctrl_q         <= 3'b000;
      rr_ptr_q       <= 1'b0;
      burst_cnt_q    <= 8'd0;
      word_cnt_q     <= 8'd0;
      underrun_q     <= 1'b0;
      word_data_q    <= 32'd0;
      word_valid_q   <= 1'b0;
      word_channel_q <= 1'b0;
    end else begin
      if (reg_wr) ctrl_q <= bus.i_data_in[2:0];

      if (flush)
        burst_cnt_q <= 8'd0;
      else if ((state_q == IDLE) && any_elig)
        burst_cnt_q <= 8'd0;
      else if (consume)
        burst_cnt_q <= burst_cnt_q + 8'd1;

      if (flush)
        word_cnt_q <= 8'd0;
      else if (consume)
        word_cnt_q <= word_cnt_q + 8'd1;

      if (consume && burst_done) rr_ptr_q <= !grant_q;

      if (stray_req)
        underrun_q <= 1'b1;
      else if (reg_rd && (bus.i_ioc == 5'd2))
        underrun_q <= 1'b0;

      if (flush)
        word_valid_q <= 1'b0;
      else if (state_q == LATCH)
        word_valid_q <= 1'b1;
      else if (consume)
        word_valid_q <= 1'b0;

      if ((state_q == LATCH) && !flush) begin
        word_data_q    <= grant_q ? bus.i_ch1_fifo_data : bus.i_ch0_fifo_data;
        word_channel_q <= grant_q;
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus.i_ioc)
      5'd0:    rd_mux = MODULE_VERSION;
      5'd1:    rd_mux = {5'b00000, ctrl_q};
      5'd2:    rd_mux = {3'b000, underrun_q, (state_q != IDLE), word_channel_q,
                         bus.i_ch1_fifo_empty, bus.i_ch0_fifo_empty};
      5'd3:    rd_mux = word_cnt_q;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset)
      data_out_q <= 8'h00;
    else if (reg_rd)
      data_out_q <= rd_mux;
  end

  assign bus.o_data_out      = data_out_q;
  assign bus.o_ch0_fifo_pull = ch0_pull;
  assign bus.o_ch1_fifo_pull = ch1_pull;
  assign bus.o_word_data     = word_data_q;
  assign bus.o_word_valid    = word_valid_q;
  assign bus.o_word_channel  = word_channel_q;
  assign bus.o_smi_dreq      = word_valid_q;
  assign bus.dbg_state       = state_q;
  assign bus.dbg_rr_ptr      = rr_ptr_q;
endmodule

// File: tb/tb_smi_rx_stream_sched.sv
// Bench for smi_rx_stream_sched: FIFO models feed both channels, a serializer
// driver consumes words, and an expected queue checks channel/data order.
module tb_smi_rx_stream_sched;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smi_rx_stream_sched_if bus();

  smi_rx_stream_sched #(.BURST_WORDS(BW), .MODULE_VERSION(8'h02)) dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  logic [31:0] fifo0_q[$];
  logic [31:0] fifo1_q[$];
  logic [32:0] exp_q[$];
  int pull0_cnt = 0;
  int pull1_cnt = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_wc = 0;

  // FIFO models: read data is valid the cycle after a pop
  always @(posedge clk) begin
    if (bus.o_ch0_fifo_pull && fifo0_q.size() > 0) begin
      bus.i_ch0_fifo_data <= fifo0_q.pop_front();
      pull0_cnt++;
    end
    if (bus.o_ch1_fifo_pull && fifo1_q.size() > 0) begin
      bus.i_ch1_fifo_data <= fifo1_q.pop_front();
      pull1_cnt++;
    end
    bus.i_ch0_fifo_empty <= (fifo0_q.size() == 0);
    bus.i_ch1_fifo_empty <= (fifo1_q.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_ch0_fifo_pull && bus.o_ch1_fifo_pull) begin
        n_fail++;
        $display("FAIL dual_pull got=both required=at most one");
      end
      if ((bus.o_ch0_fifo_pull && bus.i_ch0_fifo_empty) || (bus.o_ch1_fifo_pull && bus.i_ch1_fifo_empty)) begin
        n_fail++;
        $display("FAIL pull_on_empty got=pull required=no pull");
      end
      if (bus.o_smi_dreq !== bus.o_word_valid) begin
        n_fail++;
        $display("FAIL dreq_eq_valid got=%b required=%b", bus.o_smi_dreq, bus.o_word_valid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [4:0] ioc, input logic [7:0] d);
    bus.i_cs = 1'b1; bus.i_load_cmd = 1'b1; bus.i_ioc = ioc; bus.i_data_in = d;
    tick();
    bus.i_cs = 1'b0; bus.i_load_cmd = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] ioc, output logic [7:0] d);
    bus.i_cs = 1'b1; bus.i_fetch_cmd = 1'b1; bus.i_ioc = ioc;
    tick();
    bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0;
    d = bus.o_data_out;
  endtask

  // Serializer driver: waits for an offered word, then consumes it at once
  task automatic serve_word(output logic [32:0] got, output bit timed_out);
    timed_out = 1'b1;
    got = '0;
    for (int i = 0; i < 64; i++) begin
      if (bus.o_word_valid) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    if (!timed_out) begin
      got = {bus.o_word_channel, bus.o_word_data};
      bus.i_word_req = 1'b1;
      tick();
      bus.i_word_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    int p0, p1;
    rst = 1'b1;
    bus.i_ioc = '0; bus.i_data_in = '0; bus.i_cs = 1'b0;
    bus.i_fetch_cmd = 1'b0; bus.i_load_cmd = 1'b0; bus.i_word_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if ({bus.o_data_out, bus.o_word_valid, bus.o_ch0_fifo_pull, bus.o_ch1_fifo_pull, bus.o_word_channel} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h required=000",
               {bus.o_data_out, bus.o_word_valid, bus.o_ch0_fifo_pull, bus.o_ch1_fifo_pull, bus.o_word_channel});
    end
    reg_read(5'd0, rd);
    n_tests++;
    if (rd !== 8'h02) begin n_fail++; $display("FAIL version got=%h required=02", rd); end
    reg_read(5'd1, rd);
    n_tests++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got=%h required=00", rd); end
    reg_read(5'd3, rd);
    n_tests++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_word_cnt got=%h required=00", rd); end
    fifo0_q.push_back(32'h1111_1111);
    fifo1_q.push_back(32'h2222_2222);
    p0 = pull0_cnt; p1 = pull1_cnt;
    repeat (8) tick();
    n_tests++;
    if (pull0_cnt != p0 || pull1_cnt != p1) begin
      n_fail++;
      $display("FAIL disabled_pulls got=%0d required=0", (pull0_cnt - p0) + (pull1_cnt - p1));
    end
    fifo0_q.delete();
    fifo1_q.delete();
    repeat (2) tick();
  endtask

  task automatic test_single_word();
    logic [7:0] rd;
    logic [32:0] e;
    fifo0_q.push_back(32'hA1B2_C3D4);
    exp_q.push_back({1'b0, 32'hA1B2_C3D4});
    repeat (2) tick();
    reg_write(5'd1, 8'h01);
    n_tests++;
    if (bus.o_ch0_fifo_pull !== 1'b0) begin n_fail++; $display("FAIL single_pull_n got=%b required=0", bus.o_ch0_fifo_pull); end
    tick();
    n_tests++;
    if (bus.o_ch0_fifo_pull !== 1'b1) begin n_fail++; $display("FAIL single_pull_n1 got=%b required=1", bus.o_ch0_fifo_pull); end
    tick();
    n_tests++;
    if ({bus.o_ch0_fifo_pull, bus.o_word_valid} !== 2'b00) begin
      n_fail++; $display("FAIL single_n2 got=%b required=00", {bus.o_ch0_fifo_pull, bus.o_word_valid});
    end
    tick();
    n_tests++;
    if ({bus.o_word_valid, bus.o_smi_dreq} !== 2'b11) begin
      n_fail++; $display("FAIL single_valid_n3 got=%b required=11", {bus.o_word_valid, bus.o_smi_dreq});
    end
    e = exp_q.pop_front();
    n_tests++;
    if ({bus.o_word_channel, bus.o_word_data} !== e) begin
      n_fail++; $display("FAIL single_word got=%h required=%h", {bus.o_word_channel, bus.o_word_data}, e);
    end
    bus.i_word_req = 1'b1;
    tick();
    bus.i_word_req = 1'b0;
    exp_wc++;
    n_tests++;
    if (bus.o_word_valid !== 1'b0) begin n_fail++; $display("FAIL single_consumed got=%b required=0", bus.o_word_valid); end
    reg_read(5'd3, rd);
    n_tests++;
    if (rd !== 8'(exp_wc)) begin n_fail++; $display("FAIL single_word_cnt got=%h required=%h", rd, 8'(exp_wc)); end
  endtask

  task automatic test_early_end_underrun();
    logic [7:0] rd;
    logic [32:0] got, e;
    bit to;
    reg_write(5'd1, 8'h00);
    for (int i = 0; i < 2; i++) begin
      fifo1_q.push_back(32'h2400_0001 + 32'(i));
      exp_q.push_back({1'b1, 32'h2400_0001 + 32'(i)});
    end
    repeat (2) tick();
    reg_write(5'd1, 8'h02);
    for (int i = 0; i < 2; i++) begin
      serve_word(got, to);
      e = exp_q.pop_front();
      n_tests++;
      if (to || got !== e) begin n_fail++; $display("FAIL early_word%0d got=%h required=%h timeout=%0d", i, got, e, to); end
    end
    exp_wc += 2;
    repeat (3) tick();
    n_tests++;
    if ({bus.dbg_state, bus.dbg_rr_ptr} !== 3'b000) begin
      n_fail++; $display("FAIL early_idle_rr got=%b required=000", {bus.dbg_state, bus.dbg_rr_ptr});
    end
    bus.i_word_req = 1'b1;
    tick();
    bus.i_word_req = 1'b0;
    reg_read(5'd2, rd);
    n_tests++;
    if (rd !== 8'h17) begin n_fail++; $display("FAIL underrun_set got=%h required=17", rd); end
    reg_read(5'd2, rd);
    n_tests++;
    if (rd !== 8'h07) begin n_fail++; $display("FAIL underrun_clear got=%h required=07", rd); end
    reg_read(5'd3, rd);
    n_tests++;
    if (rd !== 8'(exp_wc)) begin n_fail++; $display("FAIL early_word_cnt got=%h required=%h", rd, 8'(exp_wc)); end
  endtask

  task automatic test_round_robin();
    logic [32:0] got, e;
    bit to;
    int rem[2];
    int ptr, ch, n;
    reg_write(5'd1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      fifo0_q.push_back(32'hC0DE_0000 + 32'(i));
      fifo1_q.push_back(32'h1BAD_0000 + 32'(i));
    end
    rem[0] = 10; rem[1] = 10; ptr = 0;
    while (rem[0] + rem[1] > 0) begin
      ch = (rem[ptr] > 0) ? ptr : 1 - ptr;
      n = (rem[ch] < BW) ? rem[ch] : BW;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({ch[0], ((ch == 0) ? 32'hC0DE_0000 : 32'h1BAD_0000) + 32'(10 - rem[ch])});
        rem[ch]--;
      end
      ptr = 1 - ch;
    end
    repeat (2) tick();
    reg_write(5'd1, 8'h03);
    for (int i = 0; i < 20; i++) begin
      serve_word(got, to);
      e = exp_q.pop_front();
      n_tests++;
      if (to || got !== e) begin n_fail++; $display("FAIL rr_word%0d got=%h required=%h timeout=%0d", i, got, e, to); end
    end
    exp_wc += 20;
  endtask

  task automatic test_fixed_priority();
    logic [32:0] got, e;
    bit to, seen_ch1;
    reg_write(5'd1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      fifo0_q.push_back(32'h5A5A_0000 + 32'(i));
      fifo1_q.push_back(32'hA5A5_0000 + 32'(i));
    end
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, 32'h5A5A_0000 + 32'(i)});
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b1, 32'hA5A5_0000 + 32'(i)});
    repeat (2) tick();
    reg_write(5'd1, 8'h07);
    seen_ch1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      serve_word(got, to);
      e = exp_q.pop_front();
      n_tests++;
      if (to || got !== e) begin n_fail++; $display("FAIL prio_word%0d got=%h required=%h timeout=%0d", i, got, e, to); end
      if (got[32] && !seen_ch1) begin
        seen_ch1 = 1'b1;
        n_tests++;
        if (bus.i_ch0_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL prio_ch0_empty got=%b required=1", bus.i_ch0_fifo_empty); end
      end
    end
    exp_wc += 20;
  endtask

  task automatic test_flush();
    logic [7:0] rd;
    logic [32:0] got, e;
    bit to;
    reg_write(5'd1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      fifo0_q.push_back(32'hF000_0000 + 32'(i));
      fifo1_q.push_back(32'hF100_0000 + 32'(i));
    end
    exp_q.push_back({1'b0, 32'hF000_0000});
    repeat (2) tick();
    reg_write(5'd1, 8'h03);
    to = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (bus.o_word_valid) begin to = 1'b0; break; end
      tick();
    end
    e = exp_q.pop_front();
    n_tests++;
    if (to || {bus.o_word_channel, bus.o_word_data} !== e) begin
      n_fail++; $display("FAIL flush_first got=%h required=%h timeout=%0d", {bus.o_word_channel, bus.o_word_data}, e, to);
    end
    bus.i_cs = 1'b1; bus.i_load_cmd = 1'b1; bus.i_ioc = 5'd1; bus.i_data_in = 8'h0B;
    bus.i_word_req = 1'b1;
    tick();
    bus.i_cs = 1'b0; bus.i_load_cmd = 1'b0; bus.i_word_req = 1'b0;
    exp_wc = 0;
    n_tests++;
    if ({bus.o_word_valid, bus.dbg_state} !== 3'b000) begin
      n_fail++; $display("FAIL flush_idle got=%b required=000", {bus.o_word_valid, bus.dbg_state});
    end
    reg_read(5'd3, rd);
    n_tests++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL flush_word_cnt got=%h required=00", rd); end
    reg_read(5'd2, rd);
    n_tests++;
    if (rd[4] !== 1'b0) begin n_fail++; $display("FAIL flush_underrun got=%b required=0", rd[4]); end
    reg_read(5'd1, rd);
    n_tests++;
    if (rd !== 8'h03) begin n_fail++; $display("FAIL flush_ctrl got=%h required=03", rd); end
    for (int i = 1; i < 3; i++) exp_q.push_back({1'b0, 32'hF000_0000 + 32'(i)});
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 32'hF100_0000 + 32'(i)});
    for (int i = 0; i < 5; i++) begin
      serve_word(got, to);
      e = exp_q.pop_front();
      n_tests++;
      if (to || got !== e) begin n_fail++; $display("FAIL resume_word%0d got=%h required=%h timeout=%0d", i, got, e, to); end
    end
    exp_wc += 5;
    reg_read(5'd3, rd);
    n_tests++;
    if (rd !== 8'(exp_wc)) begin n_fail++; $display("FAIL resume_word_cnt got=%h required=%h", rd, 8'(exp_wc)); end
    reg_read(5'd9, rd);
    n_tests++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL unmapped_read got=%h required=00", rd); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_early_end_underrun();
    test_round_robin();
    test_fixed_priority();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
